mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Second-generation FSM controller for the multicycle RV32I core. It adds branches, JALR, LUI/AUIPC writeback, illegal-opcode trap, a variable-latency memory handshake with optional timeout, and a retire strobe. It drives the shared datapath (PC, oldPC, IR, A/B, ALUOut, MDR) through mux selects and write strobes. It sits beside the datapath and replaces the first-generation controller.

Parameters:
ALU_CTRL_W, 4, width of alu_control (fixed codes: AND 0, OR 1, ADD 2, XOR 3, SLL 4, SRL 5, SUB 6, SLT 7, SRA 8, SLTU 9)
MEM_TIMEOUT, 0, max cycles a memory request waits for mem_ready before trap; 0 disables the timeout
TIMEOUT_W, 8, width of the wait counter; requires MEM_TIMEOUT < 2**TIMEOUT_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
alu_zero  in  1  A-B==0 (valid in EX_B)
alu_lt  in  1  signed A<B
alu_ltu  in  1  unsigned A<B
mem_ready  in  1  memory completes the current request this cycle
state  out  5  current FSM state
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write qualifier for mem_req
ir_write  out  1  load IR, and latch oldPC<=PC
pc_write  out  1  load PC
pc_src  out  1  0 = ALU result, 1 = ALUOut
alu_src_a  out  2  00 PC, 01 oldPC, 10 A, 11 zero
alu_src_b  out  2  00 B, 01 imm, 10 const 4
alu_control  out  ALU_CTRL_W  ALU op
imm_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J
reg_write  out  1  register-file write
result_src  out  2  00 ALUOut, 01 MDR, 10 PC (link value)
retired  out  1  1-cycle pulse on the final cycle of each instruction
halted  out  1  sticky; set after EBREAK
trap  out  1  sticky; set on illegal instruction or memory timeout

Behaviour:
- Reset: state<=FETCH on the clk edge where reset=1. While reset=1, all strobes (mem_req, mem_we, ir_write, pc_write, reg_write, retired) are forced to 0. halted and trap clear. The wait counter clears. Reset overrides every state, including HALT and TRAP.
- All outputs are decoded combinationally from state plus inputs. Unlisted outputs are 0 in each state.
- FETCH: mem_req=1, src_a=PC, src_b=4, ADD. If mem_ready: ir_write=1, pc_write=1 (pc_src=0), go to DECODE. Otherwise stay.
- DECODE: src_a=oldPC, src_b=imm, ADD, imm_src by opcode (B or J) → ALUOut holds the target. Dispatch: LW→EX_I; SW→EX_S; OP-IMM→EX_I; OP→EX_R; BRANCH→EX_B; JAL→EX_J; JALR→EX_JR; LUI/AUIPC→EX_U; SYSTEM→HALT; any other opcode→TRAP.
- EX_R: src A,B; op from {funct7,funct3}. Undefined combinations go to TRAP. Next state WB_ALU.
- EX_I: src A,imm, imm_src=I. Loads use ADD; OP-IMM decodes funct3, with SRAI when funct7=0100000. Next state MEM_RD for a load, otherwise WB_ALU.
- EX_S: A+imm(S), then MEM_WR.
- EX_B: src A,B, SUB. Taken condition by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu. If taken: pc_write=1, pc_src=1. funct3 010/011 go to TRAP. Otherwise retired=1 and the next state is FETCH.
- EX_J: reg_write=1, result_src=PC, pc_write=1, pc_src=1, retired=1, then FETCH. The register file captures the old PC+4 before the PC updates.
- EX_JR: A+imm(I) → ALUOut, then JR_WB.
- JR_WB: same as EX_J. The datapath clears ALUOut[0].
- EX_U: imm_src=U, ADD. src_a is zero for LUI and oldPC for AUIPC. Next state WB_ALU.
- MEM_RD / MEM_WR: mem_req=1 (mem_we=1 in MEM_WR). Stay until mem_ready, then go to WB_MEM or FETCH respectively. MEM_WR pulses retired on mem_ready.
- WB_ALU / WB_MEM: reg_write=1, result_src 00 or 01, retired=1, then FETCH.
- HALT / TRAP: absorbing states with all strobes 0. halted or trap is held at 1.
- Zero-wait latency:
  - ALU ops, LUI, AUIPC: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - branch, JAL: 3 cycles
  - JALR: 4 cycles
- Wait counter (MEM_TIMEOUT>0):
  - Increments each cycle in FETCH, MEM_RD or MEM_WR while mem_ready=0.
  - Clears on mem_ready or on any state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP.
  - If mem_ready is 1 in that same cycle, mem_ready wins and the FSM proceeds normally.

Optional Feature:
MC_PERF_COUNTERS_EN:
- Enabled: adds outputs cycle_count[63:0] and instret_count[63:0].
  - cycle_count increments every non-reset cycle outside HALT and TRAP.
  - instret_count increments on retired.
  - Both clear on reset and wrap modulo 2^64.
- Disabled: neither port nor either counter exists.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding
  - opcode constants
  - ALU code constants
  - imm_src, src_a/b and result_src encodings
- One combinational sub-module, mc_alu_decoder, maps (opcode, funct3, funct7, state) to alu_control plus an illegal flag.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with mem_ready tied to 1 → states FETCH,DECODE,EX_R,WB_ALU; alu_control=2 in EX_R; reg_write and retired pulse in cycle 4.
- LW with mem_ready delayed 3 cycles in MEM_RD → mem_req held 3 cycles; WB_MEM follows with result_src=01; total 8 cycles.
- BNE with alu_zero=0 → pc_write=1, pc_src=1 in EX_B. With alu_zero=1 → pc_write=0. Both take 3 cycles.
- JAL → EX_J asserts reg_write (result_src=10) and pc_write together. Opcode 0x7F → TRAP, trap=1 held for 20 cycles.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH → TRAP after the 4th wait cycle. A separate run with mem_ready=1 on that cycle → DECODE.
- EBREAK → HALT. Then reset=1 for 1 cycle → state=FETCH and halted=0. Under MC_PERF_COUNTERS_EN, instret_count=0 after the reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle RV32I controller:
//   - FSM state encoding (5 bits, exported on the 'state' port)
//   - RV32I major opcode constants
//   - ALU operation codes driven on alu_control
//   - imm_src, alu_src_a, alu_src_b and result_src mux encodings
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,
        S_DECODE = 5'd1,
        S_EX_R   = 5'd2,
        S_EX_I   = 5'd3,
        S_EX_S   = 5'd4,
        S_EX_B   = 5'd5,
        S_EX_J   = 5'd6,
        S_EX_JR  = 5'd7,
        S_JR_WB  = 5'd8,
        S_EX_U   = 5'd9,
        S_MEM_RD = 5'd10,
        S_MEM_WR = 5'd11,
        S_WB_ALU = 5'd12,
        S_WB_MEM = 5'd13,
        S_HALT   = 5'd14,
        S_TRAP   = 5'd15
    } state_e;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU operation codes
    typedef logic [3:0] alu_code_t;
    localparam alu_code_t ALU_AND  = 4'd0;
    localparam alu_code_t ALU_OR   = 4'd1;
    localparam alu_code_t ALU_ADD  = 4'd2;
    localparam alu_code_t ALU_XOR  = 4'd3;
    localparam alu_code_t ALU_SLL  = 4'd4;
    localparam alu_code_t ALU_SRL  = 4'd5;
    localparam alu_code_t ALU_SUB  = 4'd6;
    localparam alu_code_t ALU_SLT  = 4'd7;
    localparam alu_code_t ALU_SRA  = 4'd8;
    localparam alu_code_t ALU_SLTU = 4'd9;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_REG   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Register-file write data select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_PC     = 2'b10;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/mc_alu_decoder.sv
// -----------------------------------------------------------------------------
// mc_alu_decoder
// Combinational ALU-op decoder for the multicycle controller.
// Ports:
//   opcode_i  [6:0]  IR[6:0]
//   funct3_i  [2:0]  IR[14:12]
//   funct7_i  [6:0]  IR[31:25]
//   state_i          current controller state
//   alu_o     [3:0]  ALU operation code for this state
//   illegal_o        instruction fields are not a valid encoding for this state
// -----------------------------------------------------------------------------
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  state_e     state_i,
    output alu_code_t  alu_o,
    output logic       illegal_o
);

    always_comb begin
        alu_o     = ALU_AND;
        illegal_o = 1'b0;
        case (state_i)
            S_FETCH, S_DECODE, S_EX_S, S_EX_JR, S_EX_U: alu_o = ALU_ADD;

            S_EX_B: begin
                // Branch compares are done on A-B; flags come back from the ALU.
                alu_o     = ALU_SUB;
                illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
            end

            S_EX_R: begin
                case ({funct7_i, funct3_i})
                    {F7_ZERO, 3'b000}: alu_o = ALU_ADD;
                    {F7_ALT,  3'b000}: alu_o = ALU_SUB;
                    {F7_ZERO, 3'b001}: alu_o = ALU_SLL;
                    {F7_ZERO, 3'b010}: alu_o = ALU_SLT;
                    {F7_ZERO, 3'b011}: alu_o = ALU_SLTU;
                    {F7_ZERO, 3'b100}: alu_o = ALU_XOR;
                    {F7_ZERO, 3'b101}: alu_o = ALU_SRL;
                    {F7_ALT,  3'b101}: alu_o = ALU_SRA;
                    {F7_ZERO, 3'b110}: alu_o = ALU_OR;
                    {F7_ZERO, 3'b111}: alu_o = ALU_AND;
                    default:           illegal_o = 1'b1;
                endcase
            end

            S_EX_I: begin
                if (opcode_i == OPC_LOAD) begin
                    alu_o = ALU_ADD;
                end else begin
                    case (funct3_i)
                        3'b000: alu_o = ALU_ADD;
                        3'b010: alu_o = ALU_SLT;
                        3'b011: alu_o = ALU_SLTU;
                        3'b100: alu_o = ALU_XOR;
                        3'b110: alu_o = ALU_OR;
                        3'b111: alu_o = ALU_AND;
                        3'b001: begin
                            // Shift immediates reuse funct7 as the upper imm bits.
                            alu_o     = ALU_SLL;
                            illegal_o = (funct7_i != F7_ZERO);
                        end
                        default: begin
                            if (funct7_i == F7_ZERO) begin
                                alu_o = ALU_SRL;
                            end else if (funct7_i == F7_ALT) begin
                                alu_o = ALU_SRA;
                            end else begin
                                illegal_o = 1'b1;
                            end
                        end
                    endcase
                end
            end

            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multicycle RV32I FSM controller. Drives the shared datapath (PC, oldPC, IR,
// A/B, ALUOut, MDR) with mux selects and write strobes decoded from the
// current state and inputs.
//
// Parameters: ALU_CTRL_W (alu_control width), MEM_TIMEOUT (memory wait limit,
// 0 = no limit), TIMEOUT_W (wait counter width).
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   opcode/funct3/funct7           instruction fields from IR
//   alu_zero/alu_lt/alu_ltu        ALU compare flags for branches
//   mem_ready                      memory completes the current request
//   state                          current FSM state
//   mem_req/mem_we                 memory request and write qualifier
//   ir_write/pc_write/pc_src       IR/oldPC load, PC load and PC source
//   alu_src_a/alu_src_b/alu_control/imm_src   ALU operand and op selects
//   reg_write/result_src           register-file write and data select
//   retired                        pulse on the last cycle of an instruction
//   halted/trap                    sticky EBREAK / fault indicators
//
// Build option MC_PERF_COUNTERS_EN adds cycle_count and instret_count (64 bit).
// -----------------------------------------------------------------------------
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    input  logic                  mem_ready,
    output logic [4:0]            state,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            imm_src,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic                  retired,
    output logic                  halted,
    output logic                  trap
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [63:0]           cycle_count,
    output logic [63:0]           instret_count
`endif
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    // Count value seen on the last permitted wait cycle.
    localparam int TO_LAST    = TIMEOUT_EN ? MEM_TIMEOUT - 1 : 0;

    state_e                 state_q, state_d;
    logic   [TIMEOUT_W-1:0] wait_q, wait_d;
    alu_code_t              alu_code;
    logic                   illegal;
    logic                   br_taken;
    logic                   mem_state;
    logic                   timeout_hit;

    mc_alu_decoder u_alu_dec (
        .opcode_i  (opcode),
        .funct3_i  (funct3),
        .funct7_i  (funct7),
        .state_i   (state_q),
        .alu_o     (alu_code),
        .illegal_o (illegal)
    );

    always_comb begin
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            3'b110:  br_taken = alu_ltu;
            3'b111:  br_taken = !alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready in the limit cycle still completes the access.
    assign timeout_hit = TIMEOUT_EN && mem_state && !mem_ready
                         && (wait_q == TIMEOUT_W'(TO_LAST));

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_REG;
        imm_src     = IMM_I;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        retired     = 1'b0;
        alu_control = ALU_CTRL_W'(alu_code);

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // oldPC + imm lands in ALUOut as the branch/JAL target.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                if (opcode == OPC_BRANCH) begin
                    imm_src = IMM_B;
                end else if (opcode == OPC_JAL) begin
                    imm_src = IMM_J;
                end
                case (opcode)
                    OPC_LOAD, OPC_OPIMM: state_d = S_EX_I;
                    OPC_STORE:           state_d = S_EX_S;
                    OPC_OP:              state_d = S_EX_R;
                    OPC_BRANCH:          state_d = S_EX_B;
                    OPC_JAL:             state_d = S_EX_J;
                    OPC_JALR:            state_d = S_EX_JR;
                    OPC_LUI, OPC_AUIPC:  state_d = S_EX_U;
                    OPC_SYSTEM:          state_d = S_HALT;
                    default:             state_d = S_TRAP;
                endcase
            end

            S_EX_R: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                state_d   = illegal ? S_TRAP : S_WB_ALU;
            end

            S_EX_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                if (illegal) begin
                    state_d = S_TRAP;
                end else begin
                    state_d = (opcode == OPC_LOAD) ? S_MEM_RD : S_WB_ALU;
                end
            end

            S_EX_S: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_S;
                state_d   = S_MEM_WR;
            end

            S_EX_B: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                if (illegal) begin
                    state_d = S_TRAP;
                end else begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                end
            end

            S_EX_J, S_JR_WB: begin
                // PC still holds the link value (PC+4) this cycle, so the
                // register write and the PC update can share the edge.
                reg_write  = 1'b1;
                result_src = RES_PC;
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                retired    = 1'b1;
                state_d    = S_FETCH;
            end

            S_EX_JR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                state_d   = S_JR_WB;
            end

            S_EX_U: begin
                alu_src_a = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
                state_d   = S_WB_ALU;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_WB_ALU: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                retired    = 1'b1;
                state_d    = S_FETCH;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MDR;
                retired    = 1'b1;
                state_d    = S_FETCH;
            end

            S_HALT, S_TRAP: ;

            default: state_d = S_TRAP;
        endcase

        if (timeout_hit) begin
            state_d = S_TRAP;
        end

        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retired   = 1'b0;
        end
    end

    // Counter restarts whenever the access completes or the state moves on.
    assign wait_d = (TIMEOUT_EN && mem_state && !mem_ready && (state_d == state_q))
                    ? wait_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state  = state_q;
    assign halted = (state_q == S_HALT);
    assign trap   = (state_q == S_TRAP);

`ifdef MC_PERF_COUNTERS_EN
    logic [63:0] cycle_q, instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != S_HALT) && (state_q != S_TRAP)) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (retired) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_control_unit
// Directed bench for mc_control_unit. Per-cycle expected outputs are queued
// as each instruction is set up and compared as the controller steps through
// it. A second instance with MEM_TIMEOUT=4 covers the memory wait limit.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [4:0] st;
        logic       mreq, mwe, irw, pcw, pcs, rw;
        logic [1:0] rs;
        logic       ret;
        logic [3:0] alu;
        logic       hlt, trp;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic       rdy, z, lt, ltu;
        logic       dc;
        logic       mchk;
        logic [6:0] mux;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, alu_zero, alu_lt, alu_ltu, mem_ready;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] state;
    logic       mem_req, mem_we, ir_write, pc_write, pc_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_control;
    logic [2:0] imm_src;
    logic       reg_write, retired, halted, trap;
`ifdef MC_PERF_COUNTERS_EN
    logic [63:0] cycle_count, instret_count, t_cycle_count, t_instret_count;
`endif

    logic       t_reset, t_mem_ready;
    logic [4:0] t_state;
    logic       t_mem_req, t_mem_we, t_ir_write, t_pc_write, t_pc_src;
    logic [1:0] t_alu_src_a, t_alu_src_b, t_result_src;
    logic [3:0] t_alu_control;
    logic [2:0] t_imm_src;
    logic       t_reg_write, t_retired, t_halted, t_trap;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
        .state(state), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
        .result_src(result_src), .retired(retired), .halted(halted), .trap(trap)
`ifdef MC_PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    mc_control_unit #(.MEM_TIMEOUT(4)) u_to (
        .clk(clk), .reset(t_reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(t_mem_ready),
        .state(t_state), .mem_req(t_mem_req), .mem_we(t_mem_we), .ir_write(t_ir_write),
        .pc_write(t_pc_write), .pc_src(t_pc_src), .alu_src_a(t_alu_src_a),
        .alu_src_b(t_alu_src_b), .alu_control(t_alu_control), .imm_src(t_imm_src),
        .reg_write(t_reg_write), .result_src(t_result_src), .retired(t_retired),
        .halted(t_halted), .trap(t_trap)
`ifdef MC_PERF_COUNTERS_EN
        , .cycle_count(t_cycle_count), .instret_count(t_instret_count)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    string tag = "init";
    step_t q[$];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // stb = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write}; ht = {halted, trap}
    task automatic push(input state_e st, input logic [5:0] stb, input logic [1:0] rs,
                        input logic ret, input logic [3:0] alu, input logic [1:0] ht,
                        input logic rdy, input logic z);
        step_t s;
        s.e.st = st;
        {s.e.mreq, s.e.mwe, s.e.irw, s.e.pcw, s.e.pcs, s.e.rw} = stb;
        s.e.rs  = rs;
        s.e.ret = ret;
        s.e.alu = alu;
        {s.e.hlt, s.e.trp} = ht;
        s.rdy  = rdy;
        s.z    = z;
        s.lt   = 1'b0;
        s.ltu  = 1'b0;
        s.dc   = 1'b0;
        s.mchk = 1'b0;
        s.mux  = '0;
        q.push_back(s);
    endtask

    task automatic last_mux(input logic [6:0] m);
        q[q.size()-1].mchk = 1'b1;
        q[q.size()-1].mux  = m;
    endtask

    task automatic last_flags(input logic lt, input logic ltu);
        q[q.size()-1].lt  = lt;
        q[q.size()-1].ltu = ltu;
    endtask

    task automatic fetch_ok();
        push(S_FETCH, 6'b101100, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic decode();
        push(S_DECODE, 6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic set_instr(input string t, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7);
        tag    = t;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // Called on a falling edge; steps one clock per queued entry.
    task automatic run_q();
        step_t s;
        exp_t  obs;
        while (q.size() > 0) begin
            s = q.pop_front();
            mem_ready = s.rdy;
            alu_zero  = s.z;
            alu_lt    = s.lt;
            alu_ltu   = s.ltu;
            #1;
            obs.st   = state;
            obs.mreq = mem_req;
            obs.mwe  = mem_we;
            obs.irw  = ir_write;
            obs.pcw  = pc_write;
            obs.pcs  = pc_src;
            obs.rw   = reg_write;
            obs.rs   = result_src;
            obs.ret  = retired;
            obs.alu  = s.dc ? s.e.alu : alu_control;
            obs.hlt  = halted;
            obs.trp  = trap;
            chk({tag, "_cycle"}, 64'(obs), 64'(s.e));
            if (s.mchk) chk({tag, "_mux"}, 64'({alu_src_a, alu_src_b, imm_src}), 64'(s.mux));
            @(negedge clk);
        end
    endtask

    // Called on a falling edge; holds reset for one rising edge.
    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_strobes", 64'({mem_req, mem_we, ir_write, pc_write, reg_write, retired}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_state", 64'({state, halted, trap}), 64'({S_FETCH, 1'b0, 1'b0}));
`ifdef MC_PERF_COUNTERS_EN
        chk("rst_instret", instret_count, 64'd0);
        chk("rst_cycles", cycle_count, 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        t_reset     = 1'b1;
        t_mem_ready = 1'b0;
        mem_ready   = 1'b1;
        alu_zero    = 1'b0;
        alu_lt      = 1'b0;
        alu_ltu     = 1'b0;
        opcode      = 7'd0;
        funct3      = 3'd0;
        funct7      = 7'd0;
        @(negedge clk);
        do_reset();

        // ADD x3,x1,x2
        set_instr("add", 7'b0110011, 3'b000, 7'b0000000);
        fetch_ok(); last_mux(7'b00_10_000);
        decode();
        push(S_EX_R,   6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0); last_mux(7'b10_00_000);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("sub", 7'b0110011, 3'b000, 7'b0100000);
        fetch_ok(); decode();
        push(S_EX_R,   6'b000000, 2'd0, 1'b0, 4'd6, 2'b00, 1'b1, 1'b0);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        // LW with three wait cycles in MEM_RD
        set_instr("lw", 7'b0000011, 3'b010, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_I, 6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push(S_MEM_RD, 6'b100000, 2'd0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
        push(S_MEM_RD, 6'b100000, 2'd0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
        push(S_WB_MEM, 6'b000001, 2'd1, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("sw", 7'b0100011, 3'b010, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_S,   6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0); last_mux(7'b10_01_001);
        push(S_MEM_WR, 6'b110000, 2'd0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
        push(S_MEM_WR, 6'b110000, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("bne_taken", 7'b1100011, 3'b001, 7'b0000000);
        fetch_ok();
        decode(); last_mux(7'b01_01_010);
        push(S_EX_B, 6'b000110, 2'd0, 1'b1, 4'd6, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("bne_not_taken", 7'b1100011, 3'b001, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_B, 6'b000000, 2'd0, 1'b1, 4'd6, 2'b00, 1'b1, 1'b1);
        run_q();

        set_instr("beq_taken", 7'b1100011, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_B, 6'b000110, 2'd0, 1'b1, 4'd6, 2'b00, 1'b1, 1'b1);
        run_q();

        set_instr("blt_taken", 7'b1100011, 3'b100, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_B, 6'b000110, 2'd0, 1'b1, 4'd6, 2'b00, 1'b1, 1'b0); last_flags(1'b1, 1'b0);
        run_q();

        set_instr("bgeu_not_taken", 7'b1100011, 3'b111, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_B, 6'b000000, 2'd0, 1'b1, 4'd6, 2'b00, 1'b1, 1'b0); last_flags(1'b0, 1'b1);
        run_q();

        set_instr("jal", 7'b1101111, 3'b000, 7'b0000000);
        fetch_ok();
        decode(); last_mux(7'b01_01_100);
        push(S_EX_J, 6'b000111, 2'd2, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("jalr", 7'b1100111, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_JR, 6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0); last_mux(7'b10_01_000);
        push(S_JR_WB, 6'b000111, 2'd2, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("lui", 7'b0110111, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_U,   6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0); last_mux(7'b11_01_011);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        set_instr("auipc", 7'b0010111, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_U,   6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0); last_mux(7'b01_01_011);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        // SRAI with a slow instruction fetch (no timeout in this instance)
        set_instr("srai", 7'b0010011, 3'b101, 7'b0100000);
        for (int i = 0; i < 2; i++) push(S_FETCH, 6'b100000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b0, 1'b0);
        fetch_ok(); decode();
        push(S_EX_I,   6'b000000, 2'd0, 1'b0, 4'd8, 2'b00, 1'b1, 1'b0);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();

        // Opcode 0x7F: trap, held
        set_instr("illegal_opc", 7'h7F, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        for (int i = 0; i < 20; i++) push(S_TRAP, 6'b000000, 2'd0, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0);
        run_q();
        do_reset();

        // Undefined R-type funct7 traps from EX_R
        set_instr("illegal_r", 7'b0110011, 3'b000, 7'b0000001);
        fetch_ok(); decode();
        push(S_EX_R, 6'b000000, 2'd0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
        q[q.size()-1].dc = 1'b1;
        for (int i = 0; i < 2; i++) push(S_TRAP, 6'b000000, 2'd0, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0);
        run_q();
        do_reset();

        set_instr("illegal_br", 7'b1100011, 3'b010, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_B, 6'b000000, 2'd0, 1'b0, 4'd6, 2'b00, 1'b1, 1'b0);
        push(S_TRAP, 6'b000000, 2'd0, 1'b0, 4'd0, 2'b01, 1'b1, 1'b0);
        run_q();
        do_reset();

        // EBREAK halts until reset
        set_instr("ebreak", 7'b1110011, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        for (int i = 0; i < 3; i++) push(S_HALT, 6'b000000, 2'd0, 1'b0, 4'd0, 2'b10, 1'b1, 1'b0);
        run_q();
        do_reset();

        // One ADD after reset: 4 counted cycles, 1 retirement
        set_instr("add_count", 7'b0110011, 3'b000, 7'b0000000);
        fetch_ok(); decode();
        push(S_EX_R,   6'b000000, 2'd0, 1'b0, 4'd2, 2'b00, 1'b1, 1'b0);
        push(S_WB_ALU, 6'b000001, 2'd0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0);
        run_q();
`ifdef MC_PERF_COUNTERS_EN
        #1;
        chk("perf_instret", instret_count, 64'd1);
        chk("perf_cycles", cycle_count, 64'd4);
        @(negedge clk);
`endif

        // MEM_TIMEOUT=4: four waiting FETCH cycles, then TRAP
        t_reset     = 1'b0;
        t_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait", 64'({t_state, t_mem_req}), 64'({S_FETCH, 1'b1}));
            @(negedge clk);
        end
        #1;
        chk("to_trap", 64'({t_state, t_trap}), 64'({S_TRAP, 1'b1}));
        chk("to_trap_outs", 64'({t_mem_req, t_mem_we, t_ir_write, t_pc_write, t_pc_src,
                                 t_alu_src_a, t_alu_src_b, t_alu_control, t_imm_src,
                                 t_reg_write, t_result_src, t_retired, t_halted}), 64'd0);
        @(negedge clk);

        // Same, but mem_ready arrives on the limit cycle
        t_reset = 1'b1;
        @(negedge clk);
        t_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("to_wait2", 64'(t_state), 64'(S_FETCH));
            @(negedge clk);
        end
        t_mem_ready = 1'b1;
        #1;
        chk("to_ready_irw", 64'({t_state, t_ir_write}), 64'({S_FETCH, 1'b1}));
        @(negedge clk);
        #1;
        chk("to_ready_decode", 64'({t_state, t_trap}), 64'({S_DECODE, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
